// File: rtl/time_set_ctrl_if.sv
// Button / RTC-handshake / counter-control bundle for time_set_ctrl.
// slave = controller side, master = board/RTC/counter side.
interface time_set_ctrl_if;
   logic       btn_edit;
   logic       btn_next;
   logic       btn_up;
   logic       btn_down;
   logic       wr_ack;
   logic [2:0] enable;
   logic [2:0] up;
   logic [2:0] down;
   logic [1:0] field_sel;
   logic       wr_req;
   logic       blink;
   logic       commit_err;

   modport slave (
      input  btn_edit, btn_next, btn_up, btn_down, wr_ack,
      output enable, up, down, field_sel, wr_req, blink, commit_err
   );

   modport master (
      output btn_edit, btn_next, btn_up, btn_down, wr_ack,
      input  enable, up, down, field_sel, wr_req, blink, commit_err
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set controller: RTC tracking vs. user edit of sec/min/hour counters.
// Optional hold-to-repeat on up/down is enabled by defining TSC_AUTO_REPEAT_EN.
module time_set_ctrl #(
   parameter int CNT_W         = 32,
   parameter int IDLE_TIMEOUT  = 500_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   parameter int BLINK_HALF    = 12_500_000,
   parameter int ACK_TIMEOUT   = 1024
) (
   input  logic          clk,
   input  logic          reset,
   time_set_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

   function automatic logic [2:0] field_onehot(input logic [1:0] sel);
      case (sel)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   state_t           state_r, state_s;
   logic [3:0]       btn_q_r;
   logic             armed_r;
   logic [3:0]       edge_s;
   logic             edit_e_s, next_e_s, up_e_s, down_e_s;
   logic [1:0]       field_r, field_s;
   logic [2:0]       enable_r, enable_s, up_r, up_s, down_r, down_s;
   logic             wr_req_r, wr_req_s, blink_r, blink_s, err_r, err_s;
   logic [CNT_W-1:0] idle_cnt_r, idle_cnt_s, ack_cnt_r, ack_cnt_s, blink_cnt_r, blink_cnt_s;
   logic             rep_up_s, rep_down_s;

   // armed_r masks the first post-reset cycle so a button held through reset gives no edge
   assign edge_s   = {bus.btn_edit, bus.btn_next, bus.btn_up, bus.btn_down} & ~btn_q_r & {4{armed_r}};
   assign edit_e_s = edge_s[3];
   assign next_e_s = edge_s[2];
   assign up_e_s   = edge_s[1];
   assign down_e_s = edge_s[0];

`ifdef TSC_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   logic             rep_act_r, rep_dir_r, rep_first_r;
   logic [CNT_W-1:0] rep_cnt_r;
   logic             rep_hold_s, rep_start_s, rep_fire_s;

   assign rep_hold_s  = (state_r == ST_EDIT) & ~edit_e_s & ~next_e_s &
                        (rep_dir_r ? (bus.btn_up & ~bus.btn_down) : (bus.btn_down & ~bus.btn_up));
   assign rep_start_s = (state_r == ST_EDIT) & ~edit_e_s & ~next_e_s & (up_e_s ^ down_e_s);
   assign rep_fire_s  = rep_act_r & rep_hold_s &
                        (rep_cnt_r == (rep_first_r ? DELAY_LAST : PERIOD_LAST));
   assign rep_up_s    = rep_fire_s & rep_dir_r;
   assign rep_down_s  = rep_fire_s & ~rep_dir_r;

   // Hold-to-repeat timer: first gap is the delay, later gaps the period
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_act_r   <= 1'b0;
         rep_dir_r   <= 1'b0;
         rep_first_r <= 1'b1;
         rep_cnt_r   <= CNT_ZERO;
      end else if (rep_start_s) begin
         rep_act_r   <= 1'b1;
         rep_dir_r   <= up_e_s;
         rep_first_r <= 1'b1;
         rep_cnt_r   <= CNT_ZERO;
      end else if (rep_act_r && rep_hold_s) begin
         if (rep_fire_s) begin
            rep_first_r <= 1'b0;
            rep_cnt_r   <= CNT_ZERO;
         end else begin
            rep_cnt_r   <= rep_cnt_r + CNT_ONE;
         end
      end else begin
         rep_act_r   <= 1'b0;
         rep_first_r <= 1'b1;
         rep_cnt_r   <= CNT_ZERO;
      end
   end
`else
   logic unused_repeat_s;
   assign unused_repeat_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rep_up_s        = 1'b0;
   assign rep_down_s      = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      state_s     = state_r;
      field_s     = field_r;
      up_s        = 3'b000;
      down_s      = 3'b000;
      err_s       = err_r;
      idle_cnt_s  = idle_cnt_r;
      ack_cnt_s   = ack_cnt_r;
      blink_s     = 1'b0;
      blink_cnt_s = blink_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (edit_e_s) begin
               state_s     = ST_EDIT;
               field_s     = 2'd0;
               err_s       = 1'b0;
               idle_cnt_s  = CNT_ZERO;
               blink_cnt_s = CNT_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EDIT: begin
            if (blink_cnt_r == BLINK_LAST) begin
               blink_cnt_s = CNT_ZERO;
               blink_s     = ~blink_r;
            end else begin
               blink_cnt_s = blink_cnt_r + CNT_ONE;
               blink_s     = blink_r;
            end
            if (edit_e_s) begin
               state_s   = ST_COMMIT;
               ack_cnt_s = CNT_ZERO;
               blink_s   = 1'b0;
            end else begin
               if (up_e_s && !down_e_s) begin
                  up_s = field_onehot(field_r);
               end else if (down_e_s && !up_e_s) begin
                  down_s = field_onehot(field_r);
               end else if (rep_up_s) begin
                  up_s = field_onehot(field_r);
               end else if (rep_down_s) begin
                  down_s = field_onehot(field_r);
               end else begin
                  up_s = 3'b000;
               end
               if (next_e_s) begin
                  field_s = (field_r == 2'd2) ? 2'd0 : field_r + 2'd1;
               end else begin
                  field_s = field_r;
               end
               // Activity wins over a same-cycle timeout
               if (next_e_s || up_e_s || down_e_s || rep_up_s || rep_down_s) begin
                  idle_cnt_s = CNT_ZERO;
               end else if (idle_cnt_r == IDLE_LAST) begin
                  state_s = ST_IDLE;
                  blink_s = 1'b0;
               end else begin
                  idle_cnt_s = idle_cnt_r + CNT_ONE;
               end
            end
         end
         ST_COMMIT: begin
            if (bus.wr_ack) begin
               state_s = ST_IDLE;
            end else if (ack_cnt_r == ACK_LAST) begin
               state_s = ST_IDLE;
               err_s   = 1'b1;
            end else begin
               ack_cnt_s = ack_cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      enable_s = (state_s != ST_IDLE) ? 3'b111 : 3'b000;
      wr_req_s = (state_s == ST_COMMIT);
   end

   // State, timers, edge history and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         btn_q_r     <= 4'b0000;
         armed_r     <= 1'b0;
         field_r     <= 2'd0;
         enable_r    <= 3'b000;
         up_r        <= 3'b000;
         down_r      <= 3'b000;
         wr_req_r    <= 1'b0;
         blink_r     <= 1'b0;
         err_r       <= 1'b0;
         idle_cnt_r  <= CNT_ZERO;
         ack_cnt_r   <= CNT_ZERO;
         blink_cnt_r <= CNT_ZERO;
      end else begin
         state_r     <= state_s;
         btn_q_r     <= {bus.btn_edit, bus.btn_next, bus.btn_up, bus.btn_down};
         armed_r     <= 1'b1;
         field_r     <= field_s;
         enable_r    <= enable_s;
         up_r        <= up_s;
         down_r      <= down_s;
         wr_req_r    <= wr_req_s;
         blink_r     <= blink_s;
         err_r       <= err_s;
         idle_cnt_r  <= idle_cnt_s;
         ack_cnt_r   <= ack_cnt_s;
         blink_cnt_r <= blink_cnt_s;
      end
   end

   assign bus.enable     = enable_r;
   assign bus.up         = up_r;
   assign bus.down       = down_r;
   assign bus.field_sel  = field_r;
   assign bus.wr_req     = wr_req_r;
   assign bus.blink      = blink_r;
   assign bus.commit_err = err_r;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a behavioural model predicts every output
// cycle, a monitor compares; directed test-plan scenarios followed by random stimulus.
module tb_time_set_ctrl;
   localparam int IDLE_TO = 100;
   localparam int REP_DLY = 8;
   localparam int REP_PER = 4;
   localparam int BLK_HLF = 5;
   localparam int ACK_TO  = 16;

   typedef struct packed {
      logic [2:0] en;
      logic [2:0] up;
      logic [2:0] dn;
      logic [1:0] sel;
      logic       req;
      logic       blk;
      logic       err;
   } out_t;

   logic clk = 1'b0;
   logic reset;
   time_set_ctrl_if bus();

   time_set_ctrl #(
      .CNT_W(32), .IDLE_TIMEOUT(IDLE_TO), .REPEAT_DELAY(REP_DLY),
      .REPEAT_PERIOD(REP_PER), .BLINK_HALF(BLK_HLF), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   out_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   up_cnt = 0;
   bit   cnt_en = 1'b0;

   // Reference model: mode 0 idle, 1 edit, 2 commit; timing kept as edge numbers
   initial begin
      int   edge_no, m_mode, m_sel, m_enter, m_last, m_cstart, m_rep_p, d;
      bit   m_err, m_first, m_rep_on, m_rep_dir, fire, held_ok;
      logic [3:0] b, e, m_prev;
      logic [2:0] up_o, dn_o;
      out_t r;
      edge_no = 0; m_mode = 0; m_sel = 0; m_enter = 0; m_last = 0; m_cstart = 0;
      m_rep_p = 0; m_err = 1'b0; m_first = 1'b1; m_rep_on = 1'b0; m_rep_dir = 1'b0;
      m_prev = 4'b0000;
      forever begin
         @(posedge clk);
         edge_no++;
         b = {bus.btn_edit, bus.btn_next, bus.btn_up, bus.btn_down};
         up_o = 3'b000;
         dn_o = 3'b000;
         if (reset) begin
            m_mode = 0; m_sel = 0; m_err = 1'b0; m_first = 1'b1;
            m_prev = 4'b0000; m_rep_on = 1'b0;
         end else begin
            e = m_first ? 4'b0000 : (b & ~m_prev);
            m_first = 1'b0;
            m_prev = b;
            if (m_mode == 0) begin
               if (e[3]) begin
                  m_mode = 1; m_sel = 0; m_err = 1'b0;
                  m_enter = edge_no; m_last = edge_no; m_rep_on = 1'b0;
               end
            end else if (m_mode == 1) begin
               if (e[3]) begin
                  m_mode = 2;
                  m_cstart = edge_no;
               end else begin
                  fire = 1'b0;
`ifdef TSC_AUTO_REPEAT_EN
                  held_ok = m_rep_dir ? (b[1] && !b[0]) : (b[0] && !b[1]);
                  if (m_rep_on) begin
                     if (held_ok && !e[2]) begin
                        d = edge_no - m_rep_p;
                        if (d == REP_DLY || (d > REP_DLY && (d - REP_DLY) % REP_PER == 0)) fire = 1'b1;
                     end else begin
                        m_rep_on = 1'b0;
                     end
                  end
`endif
                  if (e[1] && !e[0])      up_o = 3'(1 << m_sel);
                  else if (e[0] && !e[1]) dn_o = 3'(1 << m_sel);
                  else if (fire) begin
                     if (m_rep_dir) up_o = 3'(1 << m_sel);
                     else           dn_o = 3'(1 << m_sel);
                  end
                  if (e[2]) m_sel = (m_sel + 1) % 3;
                  if ((|e[2:0]) || fire) m_last = edge_no;
                  else if (edge_no - m_last >= IDLE_TO) m_mode = 0;
`ifdef TSC_AUTO_REPEAT_EN
                  if ((e[1] ^ e[0]) && !e[2]) begin
                     m_rep_on = 1'b1; m_rep_dir = e[1]; m_rep_p = edge_no;
                  end
`endif
               end
            end else begin
               if (bus.wr_ack) m_mode = 0;
               else if (edge_no - m_cstart >= ACK_TO) begin
                  m_mode = 0;
                  m_err = 1'b1;
               end
            end
         end
         r.en  = (m_mode != 0) ? 3'b111 : 3'b000;
         r.up  = up_o;
         r.dn  = dn_o;
         r.sel = 2'(m_sel);
         r.req = (m_mode == 2);
         r.blk = (m_mode == 1) ? ((((edge_no - m_enter) / BLK_HLF) % 2) != 0) : 1'b0;
         r.err = m_err;
         sb_q.push_back(r);
      end
   end

   // Monitor: pop the expected record for each output cycle and compare
   initial begin
      out_t a, x;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            a = '{bus.enable, bus.up, bus.down, bus.field_sel, bus.wr_req, bus.blink, bus.commit_err};
            n_chk++;
            if (a === x) n_pass++;
            else $display("FAIL outputs t=%0t got en=%b up=%b dn=%b sel=%0d req=%b blk=%b err=%b want en=%b up=%b dn=%b sel=%0d req=%b blk=%b err=%b",
                          $time, a.en, a.up, a.dn, a.sel, a.req, a.blk, a.err,
                          x.en, x.up, x.dn, x.sel, x.req, x.blk, x.err);
            if (cnt_en && bus.up != 3'b000) up_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap_edit();
      bus.btn_edit = 1'b1; step(1); bus.btn_edit = 1'b0; step(1);
   endtask

   initial begin
      int exp_pulses, lvl;
      reset = 1'b1;
      bus.btn_edit = 1'b0; bus.btn_next = 1'b0; bus.btn_up = 1'b0;
      bus.btn_down = 1'b0; bus.wr_ack = 1'b0;
      step(3);
      reset = 1'b0;
      step(2);
      // edit held 3 cycles: single entry
      bus.btn_edit = 1'b1; step(3); bus.btn_edit = 1'b0; step(2);
      // next x2, up edge, then wrap
      bus.btn_next = 1'b1; step(1); bus.btn_next = 1'b0; step(1);
      bus.btn_next = 1'b1; step(1); bus.btn_next = 1'b0; step(1);
      bus.btn_up = 1'b1; step(1); bus.btn_up = 1'b0; step(2);
      bus.btn_next = 1'b1; step(1); bus.btn_next = 1'b0; step(2);
      // simultaneous up+down
      bus.btn_up = 1'b1; bus.btn_down = 1'b1; step(2);
      bus.btn_up = 1'b0; bus.btn_down = 1'b0; step(2);
      // commit with ack 3 cycles after wr_req rises
      tap_edit();
      step(2); bus.wr_ack = 1'b1; step(1); bus.wr_ack = 1'b0; step(3);
      // commit with no ack -> timeout
      tap_edit(); step(2); tap_edit(); step(ACK_TO + 4);
      // idle timeout with blink
      tap_edit(); step(IDLE_TO + 10);
      // held up for 20 cycles
      tap_edit(); step(2);
      cnt_en = 1'b1;
      bus.btn_up = 1'b1; step(20); bus.btn_up = 1'b0; step(4);
      cnt_en = 1'b0;
      #1;
`ifdef TSC_AUTO_REPEAT_EN
      exp_pulses = 4;
`else
      exp_pulses = 1;
`endif
      n_chk++;
      if (up_cnt == exp_pulses) n_pass++;
      else $display("FAIL hold_up_pulses got %0d want %0d", up_cnt, exp_pulses);
      // reset asserted mid-edit with a button held through release
      bus.btn_next = 1'b1; reset = 1'b1; step(2); reset = 1'b0; step(3); bus.btn_next = 1'b0; step(2);
      // randomized phase: activity level changes every 200 cycles
      for (int blk = 0; blk < 20; blk++) begin
         lvl = $urandom_range(0, 3);
         for (int c = 0; c < 200; c++) begin
            if (lvl != 0) begin
               if ($urandom_range(0, 59) == 0) bus.btn_edit = ~bus.btn_edit;
               if ($urandom_range(0, 15 / lvl) == 0) bus.btn_next = ~bus.btn_next;
               if ($urandom_range(0, 10 / lvl) == 0) bus.btn_up = ~bus.btn_up;
               if ($urandom_range(0, 10 / lvl) == 0) bus.btn_down = ~bus.btn_down;
            end else begin
               bus.btn_next = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
               if ($urandom_range(0, 150) == 0) bus.btn_edit = ~bus.btn_edit;
            end
            bus.wr_ack = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step(1);
         end
      end
      reset = 1'b0;
      bus.btn_edit = 1'b0; bus.btn_next = 1'b0; bus.btn_up = 1'b0;
      bus.btn_down = 1'b0; bus.wr_ack = 1'b0;
      step(5);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the three BCD time counters (seconds, minutes, hours) between RTC-tracking mode and user edit mode. It turns raw button levels into per-field one-cycle up/down pulses, drives each counter's `enable` (0 = load from RTC, 1 = hold/edit), and hands edited values back to the RTC through a write-request handshake. It sits between the board button inputs, the counter bank and the RTC interface, and provides a blink flag for the VGA time overlay.

## Interface
- `CNT_W`, 32: width of all internal timers.
- `IDLE_TIMEOUT`, 500_000_000: cycles with no button activity in EDIT before the edit is abandoned.
- `REPEAT_DELAY`, 25_000_000: hold cycles before auto-repeat starts (used only with `TSC_AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 5_000_000: cycles between auto-repeat pulses.
- `BLINK_HALF`, 12_500_000: blink half-period in cycles.
- `ACK_TIMEOUT`, 1024: cycles COMMIT waits for `wr_ack`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_edit` in 1: level; rising edge enters EDIT or commits.
- `btn_next` in 1: level; rising edge advances the selected field.
- `btn_up` in 1: level; increments the selected field.
- `btn_down` in 1: level; decrements the selected field.
- `wr_ack` in 1: RTC write accepted.
- `enable` out 3: per-counter enable, bit0 sec, bit1 min, bit2 hour.
- `up` out 3: one-hot increment pulse per counter.
- `down` out 3: one-hot decrement pulse per counter.
- `field_sel` out 2: 0 sec, 1 min, 2 hour; 3 is never driven.
- `wr_req` out 1: RTC write request.
- `blink` out 1: overlay blink for the selected field.
- `commit_err` out 1: sticky; set when the ACK timed out.

## Operation
- All outputs are registered. Reset values: `enable`=000, `up`=`down`=000, `field_sel`=0, `wr_req`=0, `blink`=0, `commit_err`=0, state IDLE, all timers 0, edge-detect history 0.
- Each button has a one-register history. An edge is `btn & ~btn_q`.
- IDLE: `enable`=000, so the counters track the RTC. A `btn_edit` edge moves to EDIT, sets `field_sel` to 0, clears `commit_err` and the idle timer, and `enable` becomes 111. All other buttons are ignored.
- EDIT: `enable`=111.
  - A `btn_next` edge sets `field_sel` to (`field_sel`+1), wrapping 2 to 0.
  - A `btn_up` edge pulses `up[field_sel]` for one cycle; a `btn_down` edge does the same on `down`.
  - Simultaneous up and down edges produce no pulse. Both still count as activity.
  - Any button edge clears the idle timer.
  - If the idle timer reaches `IDLE_TIMEOUT`-1, go to IDLE. No write is issued, and the counters reload from the RTC.
  - A `btn_edit` edge goes to COMMIT. It takes priority over a same-cycle next, up or down edge, which is dropped.
- COMMIT: `enable`=111 and `wr_req`=1; buttons are ignored.
  - `wr_ack` drops `wr_req` and goes to IDLE.
  - After `ACK_TIMEOUT` cycles without `wr_ack`, `commit_err` is set and the state goes to IDLE.
  - `wr_ack` outside COMMIT is ignored.
- `blink` toggles every `BLINK_HALF` cycles while in EDIT. It is 0 elsewhere and restarts at 0 on EDIT entry.
- `up` and `down` are never both non-zero, and at most one bit of each is set.

## Timing
- A button level first sampled high at edge k gives the output pulse during cycle k+1, for exactly one cycle.
- A state transition sampled at edge k updates `enable`, `wr_req` and `field_sel` in cycle k+1.
- `wr_req` rises the cycle after the commit edge is sampled. It falls the cycle after `wr_ack` is sampled high.
- Reset asserted in any state puts every output at its reset value in the next cycle. A button held through reset release does not produce an edge.

## Configuration
- `TSC_AUTO_REPEAT_EN` defined: while `btn_up` (or `btn_down`) stays high in EDIT, with no field change:
  - after `REPEAT_DELAY` cycles from the initial pulse, one extra pulse is issued;
  - one more pulse follows every `REPEAT_PERIOD` cycles after that.
  - Each repeat pulse clears the idle timer.
  - Releasing the button, pressing both buttons, or a `btn_next` edge stops the repeat.
- Not defined: only edges pulse. Repeat counters and parameters are unused and the repeat logic is not synthesised.

## Test plan
All scenarios use `IDLE_TIMEOUT`=100, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4, `BLINK_HALF`=5, `ACK_TIMEOUT`=16.
- Reset, then `btn_edit` high for 3 cycles: `enable` goes 000→111 one cycle after sampling, `field_sel`=0, and only one edit event occurs.
- In EDIT, `btn_next` ×2 then `btn_up` edge: `field_sel`=2 and `up`=100 for exactly 1 cycle. A third `btn_next` wraps `field_sel` to 0.
- In EDIT, `btn_up` and `btn_down` rise together: `up`=`down`=000, and the idle timer is cleared.
- `btn_edit` edge in EDIT with `wr_ack` returned 3 cycles later: `wr_req` high for 4 cycles, then IDLE with `enable`=000 and `commit_err`=0. Repeating with no `wr_ack`: `wr_req` high for 16 cycles, then `commit_err`=1.
- No buttons for 100 cycles in EDIT: return to IDLE, `wr_req` never asserted, `blink` toggling every 5 cycles before the return and 0 after.
- With `TSC_AUTO_REPEAT_EN`, `btn_up` held 20 cycles: `up` pulses at relative cycles 1, 9, 13, 17 (4 pulses). Without the macro: 1 pulse.
